// File: rtl/dino_pkg.sv
// Shared types and widths for the dino game controller.
package dino_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DEAD  = 2'd3
    } game_state_t;

    localparam int HEIGHT_W = 7;
    localparam int VEL_W    = 6;
    localparam int SCROLL_W = 10;
    localparam int SPEED_W  = 4;

    localparam logic [15:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/dino_game_ctrl_if.sv
// Renderer-facing bundle: game outputs towards the pixel pipeline and the
// collision flag coming back from it.  The signals are level-valued and
// frame-synchronous; there is no valid/ready handshake on this bus.
interface dino_game_ctrl_if;
    import dino_pkg::*;

    game_state_t         game_state;
    logic [HEIGHT_W-1:0] dino_height;
    logic [SCROLL_W-1:0] scroll_pos;
    logic [SPEED_W-1:0]  speed;
    logic [15:0]         score_bcd;
    logic                collision;

    // Controller side: drives the game view, reads the hit flag.
    modport master (
        output game_state, dino_height, scroll_pos, speed, score_bcd,
        input  collision
    );

    // Renderer side: reads the game view, drives the hit flag.
    modport slave (
        input  game_state, dino_height, scroll_pos, speed, score_bcd,
        output collision
    );

endinterface

// File: rtl/dino_bcd_counter.sv
// Four-digit BCD score counter; clr has priority over inc, holds at 9999.
module dino_bcd_counter
    import dino_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    input  logic        clr_i,
    output logic [15:0] bcd_o
);

    logic [15:0] bcd_q, bcd_d;
    logic        carry;

    // Ripple a +1 through the digits, wrapping 9 -> 0 with carry.
    always_comb begin
        bcd_d = bcd_q;
        carry = 1'b0;
        if (clr_i) begin
            bcd_d = '0;
        end else if (inc_i && (bcd_q != BCD_MAX)) begin
            carry = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (bcd_q[4*i +: 4] == 4'd9) begin
                        bcd_d[4*i +: 4] = 4'd0;
                    end else begin
                        bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    // Score register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bcd_q <= '0;
        end else begin
            bcd_q <= bcd_d;
        end
    end

    assign bcd_o = bcd_q;

endmodule

// File: rtl/dino_game_ctrl.sv
// Game-phase sequencer: play FSM, jump physics, scroll speed ramp and score.
// All game state advances on frame_tick; outputs are straight from registers.
module dino_game_ctrl
    import dino_pkg::*;
#(
    parameter int JUMP_VEL     = 12,
    parameter int GRAVITY      = 1,
    parameter int MAX_SPEED    = 15,
    parameter int ACCEL_THRESH = 64,
    parameter int SCORE_DIV    = 4,
    parameter int DEAD_FRAMES  = 60
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic             jump_in,
    input  logic             halt_in,
    input  logic [3:0]       cfg_accel,
    input  logic [3:0]       cfg_speed,
    dino_game_ctrl_if.master bus
);

    // accum stays below ACCEL_THRESH between ticks, so one cfg_accel add fits.
    localparam int ACCUM_W = $clog2(ACCEL_THRESH + 16);
    localparam int DIV_W   = $clog2(SCORE_DIV + 1);
    localparam int DEAD_W  = $clog2(DEAD_FRAMES + 1);
    // Height sum carries two guard bits so overflow above the top is seen.
    localparam int NH_W    = HEIGHT_W + 2;

    logic                     jump_s1_q, jump_s2_q, jump_prev_q;
    logic                     halt_s1_q, halt_s2_q;
    logic                     jump_rise;
    logic                     jump_pend_q, jump_pend_d;
    logic                     coll_q, coll_d;
    logic                     coll_hit;

    game_state_t              state_q, state_d;
    logic [HEIGHT_W-1:0]      height_q, height_d;
    logic signed [VEL_W-1:0]  vel_q, vel_d;
    logic [SCROLL_W-1:0]      scroll_q, scroll_d;
    logic [SPEED_W-1:0]       speed_q, speed_d;
    logic [ACCUM_W-1:0]       accum_q, accum_d, accum_sum;
    logic [DIV_W-1:0]         div_q, div_d, div_inc;
    logic [DEAD_W-1:0]        dead_q, dead_d;
    logic signed [NH_W-1:0]   nh;
    logic                     score_inc, score_clr;
    logic [15:0]              score_bcd;

    assign jump_rise = jump_s2_q & ~jump_prev_q;
    // A press arriving on a tick cycle is kept for the following frame.
    assign jump_pend_d = frame_tick ? jump_rise : (jump_pend_q | jump_rise);
    // Hits between ticks are remembered only while running; PAUSE ignores them.
    assign coll_d   = frame_tick ? 1'b0 : (coll_q | (bus.collision && (state_q == RUN)));
    assign coll_hit = bus.collision | coll_q;

    assign accum_sum = accum_q + ACCUM_W'(cfg_accel);
    assign div_inc   = div_q + 1'b1;
    assign nh        = $signed({2'b00, height_q})
                     + $signed({{(NH_W-VEL_W){vel_q[VEL_W-1]}}, vel_q});

    // Input synchronizers, jump edge detect, pending jump and sticky hit flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_s1_q   <= 1'b0;
            jump_s2_q   <= 1'b0;
            jump_prev_q <= 1'b0;
            halt_s1_q   <= 1'b0;
            halt_s2_q   <= 1'b0;
            jump_pend_q <= 1'b0;
            coll_q      <= 1'b0;
        end else begin
            jump_s1_q   <= jump_in;
            jump_s2_q   <= jump_s1_q;
            jump_prev_q <= jump_s2_q;
            halt_s1_q   <= halt_in;
            halt_s2_q   <= halt_s1_q;
            jump_pend_q <= jump_pend_d;
            coll_q      <= coll_d;
        end
    end

    // Next-state and datapath updates for the play FSM.
    always_comb begin
        state_d   = state_q;
        height_d  = height_q;
        vel_d     = vel_q;
        scroll_d  = scroll_q;
        speed_d   = speed_q;
        accum_d   = accum_q;
        div_d     = div_q;
        dead_d    = dead_q;
        score_inc = 1'b0;
        score_clr = 1'b0;

        case (state_q)
            IDLE: begin
                speed_d = cfg_speed;
                if (frame_tick && jump_pend_q) begin
                    state_d   = RUN;
                    scroll_d  = '0;
                    accum_d   = '0;
                    div_d     = '0;
                    vel_d     = VEL_W'(JUMP_VEL);
                    score_clr = 1'b1;
                end
            end

            RUN: begin
                if (frame_tick) begin
                    if (coll_hit) begin
                        state_d = DEAD;
                        dead_d  = '0;
                    end else if (halt_s2_q) begin
                        state_d = PAUSE;
                    end else begin
                        scroll_d = scroll_q + SCROLL_W'(speed_q);

                        if (accum_sum >= ACCUM_W'(ACCEL_THRESH)) begin
                            accum_d = accum_sum - ACCUM_W'(ACCEL_THRESH);
                            if (speed_q < SPEED_W'(MAX_SPEED)) begin
                                speed_d = speed_q + 1'b1;
                            end
                        end else begin
                            accum_d = accum_sum;
                        end

                        if (div_inc == DIV_W'(SCORE_DIV)) begin
                            div_d     = '0;
                            score_inc = 1'b1;
                        end else begin
                            div_d = div_inc;
                        end

                        if ((height_q == '0) && (vel_q == '0)) begin
                            if (jump_pend_q) begin
                                vel_d = VEL_W'(JUMP_VEL);
                            end
                        end else if (nh[NH_W-1] || (nh == '0)) begin
                            // Sum at or below ground: land.
                            height_d = '0;
                            vel_d    = '0;
                        end else begin
                            // Positive sum above the top row clamps to it.
                            if (nh[HEIGHT_W]) begin
                                height_d = '1;
                            end else begin
                                height_d = nh[HEIGHT_W-1:0];
                            end
                            vel_d = vel_q - VEL_W'(GRAVITY);
                        end
                    end
                end
            end

            PAUSE: begin
                if (!halt_s2_q) begin
                    state_d = RUN;
                end
            end

            DEAD: begin
                if (frame_tick) begin
                    if (dead_q == DEAD_W'(DEAD_FRAMES)) begin
                        if (jump_pend_q) begin
                            state_d = IDLE;
                        end
                    end else begin
                        dead_d = dead_q + 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Game state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            height_q <= '0;
            vel_q    <= '0;
            scroll_q <= '0;
            speed_q  <= '0;
            accum_q  <= '0;
            div_q    <= '0;
            dead_q   <= '0;
        end else begin
            state_q  <= state_d;
            height_q <= height_d;
            vel_q    <= vel_d;
            scroll_q <= scroll_d;
            speed_q  <= speed_d;
            accum_q  <= accum_d;
            div_q    <= div_d;
            dead_q   <= dead_d;
        end
    end

    dino_bcd_counter u_score (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .inc_i  (score_inc),
        .clr_i  (score_clr),
        .bcd_o  (score_bcd)
    );

    assign bus.game_state  = state_q;
    assign bus.dino_height = height_q;
    assign bus.scroll_pos  = scroll_q;
    assign bus.speed       = speed_q;
    assign bus.score_bcd   = score_bcd;

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Directed bench for dino_game_ctrl: inputs change on the falling edge,
// outputs are checked on the falling edge after the rising edge acted.
module tb_dino_game_ctrl;
    import dino_pkg::*;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       frame_tick = 1'b0;
    logic       jump_in    = 1'b0;
    logic       halt_in    = 1'b0;
    logic [3:0] cfg_accel  = 4'd0;
    logic [3:0] cfg_speed  = 4'd0;

    int errors = 0;
    int checks = 0;

    dino_game_ctrl_if bus ();

    dino_game_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .jump_in    (jump_in),
        .halt_in    (halt_in),
        .cfg_accel  (cfg_accel),
        .cfg_speed  (cfg_speed),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [1:0] st, input logic [6:0] h,
                              input logic [9:0] sc, input logic [3:0] sp, input logic [15:0] bcd);
        check({tag, ".state"},  {14'd0, bus.game_state}, {14'd0, st});
        check({tag, ".height"}, {9'd0, bus.dino_height}, {9'd0, h});
        check({tag, ".scroll"}, {6'd0, bus.scroll_pos},  {6'd0, sc});
        check({tag, ".speed"},  {12'd0, bus.speed},      {12'd0, sp});
        check({tag, ".score"},  bus.score_bcd,           bcd);
    endtask

    // Called on a falling edge; holds frame_tick high for n rising edges.
    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) @(negedge clk);
        frame_tick = 1'b0;
    endtask

    // Called on a falling edge; long enough to pass the synchronizer.
    task automatic press_jump();
        jump_in = 1'b1;
        repeat (4) @(negedge clk);
        jump_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.collision = 1'b0;
        cfg_speed     = 4'd2;
        cfg_accel     = 4'd0;

        // Power-on reset
        repeat (2) @(negedge clk);
        check_outs("por", 2'd0, 7'd0, 10'd0, 4'd0, 16'h0000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_speed", {12'd0, bus.speed}, 16'd2);

        // Game A: constant speed 2, jump arc, BCD carry, scroll wrap
        press_jump();
        ticks(1);
        check_outs("start", 2'd1, 7'd0, 10'd0, 4'd2, 16'h0000);
        ticks(1);
        check_outs("arc1", 2'd1, 7'd12, 10'd2, 4'd2, 16'h0000);
        ticks(1);
        check("arc2", {9'd0, bus.dino_height}, 16'd23);
        ticks(1);
        check("arc3", {9'd0, bus.dino_height}, 16'd33);
        ticks(9);
        check("arc12_peak", {9'd0, bus.dino_height}, 16'd78);
        ticks(1);
        check("arc13_peak", {9'd0, bus.dino_height}, 16'd78);
        ticks(11);
        check("arc24", {9'd0, bus.dino_height}, 16'd12);
        ticks(1);
        check_outs("land", 2'd1, 7'd0, 10'd50, 4'd2, 16'h0006);
        ticks(371);
        check_outs("t396", 2'd1, 7'd0, 10'd792, 4'd2, 16'h0099);
        ticks(4);
        check_outs("carry", 2'd1, 7'd0, 10'd800, 4'd2, 16'h0100);
        ticks(111);
        check_outs("t511", 2'd1, 7'd0, 10'd1022, 4'd2, 16'h0127);
        ticks(1);
        check_outs("wrap", 2'd1, 7'd0, 10'd0, 4'd2, 16'h0128);

        // Asynchronous reset mid-run, checked before any clock edge
        #2 rst_n = 1'b0;
        #1 check_outs("async_rst", 2'd0, 7'd0, 10'd0, 4'd0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Game B: speed ramp with cfg_accel=4
        cfg_accel = 4'd4;
        @(negedge clk);
        press_jump();
        ticks(1);
        check("b_start", {14'd0, bus.game_state}, 16'd1);
        ticks(15);
        check("ramp15", {12'd0, bus.speed}, 16'd2);
        ticks(1);
        check("ramp16", {12'd0, bus.speed}, 16'd3);
        ticks(192);
        check("ramp208", {12'd0, bus.speed}, 16'd15);
        ticks(80);
        check_outs("pre_halt", 2'd1, 7'd0, 10'd816, 4'd15, 16'h0072);

        // Halt -> PAUSE on the tick, frozen while collision is high
        halt_in = 1'b1;
        repeat (3) @(negedge clk);
        check("halt_wait", {14'd0, bus.game_state}, 16'd1);
        ticks(1);
        check_outs("pause", 2'd2, 7'd0, 10'd816, 4'd15, 16'h0072);
        bus.collision = 1'b1;
        ticks(100);
        check_outs("pause_frozen", 2'd2, 7'd0, 10'd816, 4'd15, 16'h0072);
        bus.collision = 1'b0;
        halt_in = 1'b0;
        repeat (3) @(negedge clk);
        check("unpause", {14'd0, bus.game_state}, 16'd1);
        ticks(1);
        check_outs("resume", 2'd1, 7'd0, 10'd831, 4'd15, 16'h0072);

        // Collision on the tick -> DEAD with nothing updated
        bus.collision = 1'b1;
        ticks(1);
        bus.collision = 1'b0;
        check_outs("dead", 2'd3, 7'd0, 10'd831, 4'd15, 16'h0072);
        ticks(30);
        press_jump();
        ticks(1);
        check("dead_jump_ignored", {14'd0, bus.game_state}, 16'd3);
        ticks(29);
        press_jump();
        ticks(1);
        check("dead_to_idle", {14'd0, bus.game_state}, 16'd0);
        check("idle_score_hold", bus.score_bcd, 16'h0072);
        check("idle_scroll_hold", {6'd0, bus.scroll_pos}, 16'd831);
        press_jump();
        ticks(1);
        check_outs("restart", 2'd1, 7'd0, 10'd0, 4'd2, 16'h0000);

        // Collision between ticks is remembered until the next tick
        bus.collision = 1'b1;
        @(negedge clk);
        bus.collision = 1'b0;
        @(negedge clk);
        check("sticky_wait", {14'd0, bus.game_state}, 16'd1);
        ticks(1);
        check_outs("sticky_dead", 2'd3, 7'd0, 10'd0, 4'd2, 16'h0000);

        // Game C: speed 0, no ramp, score saturation
        cfg_speed = 4'd0;
        cfg_accel = 4'd0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        press_jump();
        ticks(1);
        ticks(39996);
        check_outs("sat", 2'd1, 7'd0, 10'd0, 4'd0, 16'h9999);
        ticks(4);
        check_outs("sat_hold", 2'd1, 7'd0, 10'd0, 4'd0, 16'h9999);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
